// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the ID/EX control stage: control bundle layout and EX FSM states.
package pipe_ctrl_pkg;

    localparam int unsigned CTRL_W = 8;

    // Bit positions of the fields inside the flat control bundle
    localparam int unsigned ALUOP_LSB    = 6;
    localparam int unsigned ALUSRC_BIT   = 5;
    localparam int unsigned BRANCH_BIT   = 4;
    localparam int unsigned MEMREAD_BIT  = 3;
    localparam int unsigned MEMWRITE_BIT = 2;
    localparam int unsigned REGWRITE_BIT = 1;
    localparam int unsigned MEMTOREG_BIT = 0;

    typedef struct packed {
        logic [1:0] aluOp;
        logic       aluSrc;
        logic       branch;
        logic       memRead;
        logic       memWrite;
        logic       regWrite;
        logic       memToReg;
    } ctrl_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } ex_state_e;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator between the instruction in EX and the one in ID.
module load_use_detect
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic              exValid,
    input  logic              exIsLoad,
    input  logic [REG_AW-1:0] exRd,
    input  logic              idValid,
    input  logic [REG_AW-1:0] idRs1,
    input  logic [REG_AW-1:0] idRs2,
    input  logic              idRs1Used,
    input  logic              idRs2Used,
    output logic              hazard_c
);

    logic rs1Match;
    logic rs2Match;
    logic exProducesReg;

    assign rs1Match = idRs1Used && (idRs1 == exRd);
    assign rs2Match = idRs2Used && (idRs2 == exRd);

    // x0 is hard-wired zero, so a load targeting it never has a consumer
    assign exProducesReg = exValid && exIsLoad && (exRd != '0);

    assign hazard_c = exProducesReg && idValid && (rs1Match || rs2Match);

endmodule

// File: rtl/id_ex_ctrl_stage.sv
// ID/EX control register with load-use stall/bubble insertion, flush handling
// and a saturating count of inserted bubbles.
module id_ex_ctrl_stage
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CTRL_W   = pipe_ctrl_pkg::CTRL_W,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic              i_valid,
    input  logic              i_is_load,
    input  logic [REG_AW-1:0] i_rs1,
    input  logic [REG_AW-1:0] i_rs2,
    input  logic              i_rs1_used,
    input  logic              i_rs2_used,
    input  logic [REG_AW-1:0] i_rd,
    input  logic              i_flush,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic              o_valid,
    output logic [REG_AW-1:0] o_rd,
    output logic              o_stall,
    output logic [CNT_W-1:0]  o_bubble_cnt
);

    localparam int unsigned     LAT_W      = $clog2(LOAD_LAT) + 1;
    localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    ex_state_e         state;
    ex_state_e         stateNext;
    logic [LAT_W-1:0]  cnt;
    logic [LAT_W-1:0]  cntNext;
    logic [REG_AW-1:0] ldRd;
    logic [REG_AW-1:0] ldRdNext;
    logic              exIsLoad;

    logic [CTRL_W-1:0] exCtrlNext;
    logic              exValidNext;
    logic [REG_AW-1:0] exRdNext;
    logic              exIsLoadNext;
    logic              bubbleIns;
    logic              hazard;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_detect (
        .exValid   (o_valid),
        .exIsLoad  (exIsLoad),
        .exRd      (o_rd),
        .idValid   (i_valid),
        .idRs1     (i_rs1),
        .idRs2     (i_rs2),
        .idRs1Used (i_rs1_used),
        .idRs2Used (i_rs2_used),
        .hazard_c  (hazard)
    );

    // Next-state, next-EX contents and stall decode
    always_comb begin
        stateNext    = state;
        cntNext      = cnt;
        ldRdNext     = ldRd;
        exCtrlNext   = '0;
        exValidNext  = 1'b0;
        exRdNext     = '0;
        exIsLoadNext = 1'b0;
        bubbleIns    = 1'b0;
        o_stall      = 1'b0;

        if (i_flush) begin
            stateNext = IDLE;
            cntNext   = '0;
            bubbleIns = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (hazard) begin
                        o_stall   = 1'b1;
                        bubbleIns = 1'b1;
                        if (LOAD_LAT > 1) begin
                            stateNext = STALL;
                            cntNext   = LAT_RELOAD;
                            ldRdNext  = o_rd;
                        end
                    end else if (i_valid) begin
                        exCtrlNext   = i_ctrl;
                        exValidNext  = 1'b1;
                        exRdNext     = i_rd;
                        exIsLoadNext = i_is_load;
                    end
                end
                STALL: begin
                    o_stall   = 1'b1;
                    bubbleIns = 1'b1;
                    if (cnt == LAT_W'(1)) begin
                        stateNext = IDLE;
                        cntNext   = '0;
                    end else begin
                        cntNext = cnt - LAT_W'(1);
                    end
                end
                default: begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            ldRd         <= '0;
            o_ctrl       <= '0;
            o_valid      <= 1'b0;
            o_rd         <= '0;
            exIsLoad     <= 1'b0;
            o_bubble_cnt <= '0;
        end else begin
            state    <= stateNext;
            cnt      <= cntNext;
            ldRd     <= ldRdNext;
            o_ctrl   <= exCtrlNext;
            o_valid  <= exValidNext;
            o_rd     <= exRdNext;
            exIsLoad <= exIsLoadNext;
            if (bubbleIns && (o_bubble_cnt != CNT_MAX)) begin
                o_bubble_cnt <= o_bubble_cnt + CNT_W'(1);
            end
        end
    end

`ifndef SYNTHESIS
    // A multi-cycle stall is only ever entered for a load with a real destination
    ast_stall_ld_rd : assert property (@(posedge clk) disable iff (!rst_n)
        (state == STALL) |-> (ldRd != '0));
`endif

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Checks three configurations of id_ex_ctrl_stage against a cycle-level reference model.
module tb_id_ex_ctrl_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] iCtrl;
    logic       iValid, iLoad, iRs1U, iRs2U, iFlush;
    logic [4:0] iRs1, iRs2, iRd;

    logic [7:0]  ctrlA, ctrlB, ctrlC;
    logic        validA, validB, validC;
    logic [4:0]  rdA, rdB, rdC;
    logic        stallA, stallB, stallC;
    logic [15:0] cntA, cntB;
    logic [3:0]  cntC;

    always #5 clk = ~clk;

    id_ex_ctrl_stage #(.CTRL_W(8), .REG_AW(5), .LOAD_LAT(1), .CNT_W(16)) dutA (
        .clk(clk), .rst_n(rst_n), .i_ctrl(iCtrl), .i_valid(iValid), .i_is_load(iLoad),
        .i_rs1(iRs1), .i_rs2(iRs2), .i_rs1_used(iRs1U), .i_rs2_used(iRs2U), .i_rd(iRd),
        .i_flush(iFlush), .o_ctrl(ctrlA), .o_valid(validA), .o_rd(rdA), .o_stall(stallA),
        .o_bubble_cnt(cntA));

    id_ex_ctrl_stage #(.CTRL_W(8), .REG_AW(5), .LOAD_LAT(3), .CNT_W(16)) dutB (
        .clk(clk), .rst_n(rst_n), .i_ctrl(iCtrl), .i_valid(iValid), .i_is_load(iLoad),
        .i_rs1(iRs1), .i_rs2(iRs2), .i_rs1_used(iRs1U), .i_rs2_used(iRs2U), .i_rd(iRd),
        .i_flush(iFlush), .o_ctrl(ctrlB), .o_valid(validB), .o_rd(rdB), .o_stall(stallB),
        .o_bubble_cnt(cntB));

    id_ex_ctrl_stage #(.CTRL_W(8), .REG_AW(5), .LOAD_LAT(1), .CNT_W(4)) dutC (
        .clk(clk), .rst_n(rst_n), .i_ctrl(iCtrl), .i_valid(iValid), .i_is_load(iLoad),
        .i_rs1(iRs1), .i_rs2(iRs2), .i_rs1_used(iRs1U), .i_rs2_used(iRs2U), .i_rd(iRd),
        .i_flush(iFlush), .o_ctrl(ctrlC), .o_valid(validC), .o_rd(rdC), .o_stall(stallC),
        .o_bubble_cnt(cntC));

    int total = 0;
    int bad   = 0;

    // Reference model: EX contents, remaining stall cycles and bubble tally per instance
    int         mLat [3] = '{1, 3, 1};
    int         mMax [3] = '{65535, 65535, 15};
    logic       mValid [3];
    logic [7:0] mCtrl [3];
    logic [4:0] mRd [3];
    logic       mLoad [3];
    int         mLeft [3];
    int         mCnt [3];
    logic       lastStall [3];

    function automatic logic [7:0] gCtrl(input int k);
        case (k) 0: return ctrlA; 1: return ctrlB; default: return ctrlC; endcase
    endfunction
    function automatic logic gValid(input int k);
        case (k) 0: return validA; 1: return validB; default: return validC; endcase
    endfunction
    function automatic logic [4:0] gRd(input int k);
        case (k) 0: return rdA; 1: return rdB; default: return rdC; endcase
    endfunction
    function automatic logic gStall(input int k);
        case (k) 0: return stallA; 1: return stallB; default: return stallC; endcase
    endfunction
    function automatic logic [15:0] gCnt(input int k);
        case (k) 0: return cntA; 1: return cntB; default: return {12'h000, cntC}; endcase
    endfunction

    function automatic logic mHazard(input int k);
        logic use1, use2;
        use1 = iRs1U && (iRs1 == mRd[k]);
        use2 = iRs2U && (iRs2 == mRd[k]);
        return (mLeft[k] == 0) && mValid[k] && mLoad[k] && (mRd[k] != 5'd0) && iValid && (use1 || use2);
    endfunction

    function automatic logic mStall(input int k);
        return !iFlush && ((mLeft[k] > 0) || mHazard(k));
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 3; k++) begin
            mValid[k] = 1'b0; mCtrl[k] = 8'h00; mRd[k] = 5'd0; mLoad[k] = 1'b0;
            mLeft[k] = 0; mCnt[k] = 0;
        end
    endtask

    task automatic modelClock(input int k);
        logic h, bub;
        h   = mHazard(k);
        bub = 1'b1;
        if (iFlush) mLeft[k] = 0;
        else if (mLeft[k] > 0) mLeft[k] = mLeft[k] - 1;
        else if (h) mLeft[k] = mLat[k] - 1;
        else bub = 1'b0;
        if (bub) begin
            mValid[k] = 1'b0; mCtrl[k] = 8'h00; mRd[k] = 5'd0; mLoad[k] = 1'b0;
            if (mCnt[k] < mMax[k]) mCnt[k] = mCnt[k] + 1;
        end else begin
            mValid[k] = iValid;
            mCtrl[k]  = iValid ? iCtrl : 8'h00;
            mRd[k]    = iValid ? iRd : 5'd0;
            mLoad[k]  = iValid && iLoad;
        end
    endtask

    task automatic checkRegs(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk({tag, "_ctrl"}, k, 32'(gCtrl(k)), 32'(mCtrl[k]));
            chk({tag, "_valid"}, k, 32'(gValid(k)), 32'(mValid[k]));
            chk({tag, "_rd"}, k, 32'(gRd(k)), 32'(mRd[k]));
            chk({tag, "_cnt"}, k, 32'(gCnt(k)), 32'(mCnt[k]));
        end
    endtask

    task automatic checkZeroAll(input string tag);
        checkRegs(tag);
        for (int k = 0; k < 3; k++) chk({tag, "_stall"}, k, 32'(gStall(k)), 32'd0);
    endtask

    // One clock: comb stall checked mid-cycle, registers checked just after the edge
    task automatic step();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            lastStall[k] = gStall(k);
            chk("stall", k, 32'(gStall(k)), 32'(mStall(k)));
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) modelClock(k);
        #1;
        checkRegs("ex");
    endtask

    task automatic setId(input logic v, input logic ld, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic [7:0] c);
        iValid = v; iLoad = ld; iRs1 = rs1; iRs1U = u1; iRs2 = rs2; iRs2U = u2; iRd = rd; iCtrl = c;
    endtask

    int stallsA, stallsB;

    initial begin
        rst_n  = 1'b0;
        iFlush = 1'b0;
        setId(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 8'h00);
        modelReset();
        #2;
        checkZeroAll("rst0");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Five flush bubbles, then a valid ALU op in EX, then async reset mid-cycle
        iFlush = 1'b1;
        setId(1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 8'h82);
        repeat (5) step();
        iFlush = 1'b0;
        step();
        chk("preRstValid", 0, 32'(validA), 32'd1);
        chk("preRstCnt", 0, 32'(cntA), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        checkZeroAll("rstAsync");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // lw x5 then add reading x5: LOAD_LAT=1 stalls once, LOAD_LAT=3 stalls three times
        setId(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 8'h2B);
        step();
        setId(1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 8'h82);
        stallsA = 0; stallsB = 0;
        repeat (4) begin
            step();
            stallsA += int'(lastStall[0]);
            stallsB += int'(lastStall[1]);
        end
        chk("lat1Stalls", 0, 32'(stallsA), 32'd1);
        chk("lat3Stalls", 1, 32'(stallsB), 32'd3);
        chk("lat1Cnt", 0, 32'(cntA), 32'd1);
        chk("lat3Cnt", 1, 32'(cntB), 32'd3);
        chk("addInEx", 1, 32'(rdB), 32'd6);
        chk("addCtrl", 1, 32'(ctrlB), 32'h82);

        // Load to x0 with consumer reading x0
        setId(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 8'h2B);
        step();
        setId(1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd4, 8'h82);
        step();
        for (int k = 0; k < 3; k++) chk("x0NoStall", k, 32'(lastStall[k]), 32'd0);
        chk("x0Cnt", 1, 32'(cntB), 32'd3);

        // Flush coincident with a hazard
        setId(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 8'h2B);
        step();
        setId(1'b1, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 5'd8, 8'h82);
        iFlush = 1'b1;
        step();
        iFlush = 1'b0;
        for (int k = 0; k < 3; k++) chk("flushHazStall", k, 32'(lastStall[k]), 32'd0);
        chk("flushHazCntA", 0, 32'(cntA), 32'd2);
        chk("flushHazCntB", 1, 32'(cntB), 32'd4);

        // Flush on the second cycle of a three-cycle stall
        setId(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 8'h2B);
        step();
        setId(1'b1, 1'b0, 5'd10, 1'b1, 5'd0, 1'b0, 5'd11, 8'h82);
        step();
        iFlush = 1'b1;
        step();
        iFlush = 1'b0;
        chk("midFlushStall", 1, 32'(lastStall[1]), 32'd0);
        chk("midFlushCnt", 1, 32'(cntB), 32'd6);
        step();
        chk("afterFlushStall", 1, 32'(lastStall[1]), 32'd0);
        chk("afterFlushValid", 1, 32'(validB), 32'd1);

        // Twenty hazards: four-bit counter saturates
        repeat (20) begin
            setId(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 8'h2B);
            step();
            setId(1'b1, 1'b0, 5'd3, 1'b1, 5'd7, 1'b1, 5'd2, 8'h82);
            repeat (3) step();
        end
        chk("satCnt", 2, 32'(cntC), 32'd15);
        chk("wideCnt", 1, 32'(cntB), 32'd66);

        // Reset while the three-cycle instance is in its stall state
        setId(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 8'h2B);
        step();
        setId(1'b1, 1'b0, 5'd12, 1'b1, 5'd0, 1'b0, 5'd13, 8'h82);
        step();
        chk("midStallHigh", 1, 32'(stallB), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        modelReset();
        checkZeroAll("rstStall");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) step();
        chk("noResidual", 1, 32'(cntB), 32'd0);

        // Randomized traffic over a small register window to provoke frequent hazards
        repeat (400) begin
            setId(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 8'($urandom));
            iFlush = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
